// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the fetch PC, issues one outstanding
// instruction-memory request at a time, buffers a response that arrives while
// ID is stalled in a one-entry skid, and loads the IF/ID pipeline register.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   pc_stall, if_stall, if_flush    controller hazard controls
//   branch_taken, branch_target     EX-stage redirect
//   imem_req, imem_addr             memory request (combinational)
//   imem_rvalid, imem_rdata         memory response (in order)
//   if_pc, if_insn, if_valid,
//   if_exp_misalign                 IF/ID register (registered)
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_stall,
  input  logic        if_stall,
  input  logic        if_flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_insn,
  output logic        if_valid,
  output logic        if_exp_misalign
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_IDLE,
    ST_WAIT,
    ST_WAIT_DISCARD,
    ST_EXP
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]   req_pc_q, req_pc_d;
  logic              skid_valid_q, skid_valid_d;
  logic [XLEN-1:0]   skid_pc_q, skid_pc_d;
  logic [XLEN-1:0]   skid_insn_q, skid_insn_d;
  logic              pend_mis_q, pend_mis_d;
  logic [XLEN-1:0]   if_pc_q, if_pc_d;
  logic [XLEN-1:0]   if_insn_q, if_insn_d;
  logic              if_valid_q, if_valid_d;
  logic              if_exp_q, if_exp_d;

  logic issue;
  logic accept;
  logic tgt_mis;
  logic redirect_in_flight;
  logic defer_done;

  // Request issue and response classification
  always_comb begin
    issue = ((state_q == ST_IDLE) || (state_q == ST_WAIT && imem_rvalid)) &&
            !pc_stall && !if_stall && !skid_valid_q && !branch_taken && !if_flush;
    accept             = (state_q == ST_WAIT) && imem_rvalid;
    tgt_mis            = |branch_target[1:0];
    // A redirect while the old response is still in flight must drop it later
    redirect_in_flight = (state_q == ST_WAIT) && !imem_rvalid;
    // Misaligned redirect whose exception entry waited for the dropped response
    defer_done         = (state_q == ST_WAIT_DISCARD) && imem_rvalid && pend_mis_q;
  end

  assign imem_req  = issue;
  assign imem_addr = fetch_pc_q;

  // Next-state logic for FSM, PCs, skid and IF/ID
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    req_pc_d     = req_pc_q;
    skid_valid_d = skid_valid_q;
    skid_pc_d    = skid_pc_q;
    skid_insn_d  = skid_insn_q;
    pend_mis_d   = pend_mis_q;
    if_pc_d      = if_pc_q;
    if_insn_d    = if_insn_q;
    if_valid_d   = if_valid_q;
    if_exp_d     = if_exp_q;

    if (branch_taken) begin
      fetch_pc_d   = branch_target;
      skid_valid_d = 1'b0;
      pend_mis_d   = redirect_in_flight && tgt_mis;
      if (redirect_in_flight) begin
        state_d = ST_WAIT_DISCARD;
      end else if (tgt_mis) begin
        state_d = ST_EXP;
      end else begin
        state_d = ST_IDLE;
      end
      if (tgt_mis && !redirect_in_flight) begin
        if_valid_d = 1'b1;
        if_exp_d   = 1'b1;
        if_pc_d    = branch_target;
        if_insn_d  = NOP_INSN;
      end else begin
        if_valid_d = 1'b0;
        if_exp_d   = 1'b0;
        if_insn_d  = NOP_INSN;
      end
    end else begin
      unique case (state_q)
        ST_BOOT:         state_d = ST_IDLE;
        ST_IDLE:         if (issue) state_d = ST_WAIT;
        ST_WAIT:         if (imem_rvalid && !issue) state_d = ST_IDLE;
        ST_WAIT_DISCARD: begin
          if (imem_rvalid) begin
            state_d    = pend_mis_q ? ST_EXP : ST_IDLE;
            pend_mis_d = 1'b0;
          end
        end
        ST_EXP:          state_d = ST_EXP;
        default:         state_d = ST_BOOT;
      endcase

      if (issue) begin
        req_pc_d   = fetch_pc_q;
        fetch_pc_d = XLEN'(fetch_pc_q + 32'd4);
      end

      // Response arriving while ID cannot take it is parked in the skid
      if (accept && (if_stall || skid_valid_q)) begin
        skid_valid_d = 1'b1;
        skid_pc_d    = req_pc_q;
        skid_insn_d  = imem_rdata;
      end

      if (defer_done) begin
        if_valid_d = 1'b1;
        if_exp_d   = 1'b1;
        if_pc_d    = fetch_pc_q;
        if_insn_d  = NOP_INSN;
      end else if (if_flush) begin
        if_valid_d = 1'b0;
        if_exp_d   = 1'b0;
        if_insn_d  = NOP_INSN;
      end else if (if_stall) begin
        if_valid_d = if_valid_q;
      end else if (skid_valid_q) begin
        if_valid_d   = 1'b1;
        if_exp_d     = 1'b0;
        if_pc_d      = skid_pc_q;
        if_insn_d    = skid_insn_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        if_valid_d = 1'b1;
        if_exp_d   = 1'b0;
        if_pc_d    = req_pc_q;
        if_insn_d  = imem_rdata;
      end else begin
        if_valid_d = 1'b0;
        if_exp_d   = 1'b0;
        if_insn_d  = NOP_INSN;
      end
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_BOOT;
      fetch_pc_q   <= RESET_PC;
      req_pc_q     <= '0;
      skid_valid_q <= 1'b0;
      skid_pc_q    <= '0;
      skid_insn_q  <= '0;
      pend_mis_q   <= 1'b0;
      if_pc_q      <= '0;
      if_insn_q    <= NOP_INSN;
      if_valid_q   <= 1'b0;
      if_exp_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      req_pc_q     <= req_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_pc_q    <= skid_pc_d;
      skid_insn_q  <= skid_insn_d;
      pend_mis_q   <= pend_mis_d;
      if_pc_q      <= if_pc_d;
      if_insn_q    <= if_insn_d;
      if_valid_q   <= if_valid_d;
      if_exp_q     <= if_exp_d;
    end
  end

  assign if_pc           = if_pc_q;
  assign if_insn         = if_insn_q;
  assign if_valid        = if_valid_q;
  assign if_exp_misalign = if_exp_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed testbench for if_stage with a single-outstanding memory model of
// configurable latency; responses are addr ^ 32'hA5A5_0000.
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        pc_stall;
  logic        if_stall;
  logic        if_flush;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] if_pc;
  logic [31:0] if_insn;
  logic        if_valid;
  logic        if_exp_misalign;

  int          checks;
  int          failures;
  int          lat;
  bit          mem_busy;
  int          mem_cnt;
  logic [31:0] mem_addr;
  logic        req_s;
  logic [31:0] addr_s;

  if_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_stall       (pc_stall),
    .if_stall       (if_stall),
    .if_flush       (if_flush),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .if_pc          (if_pc),
    .if_insn        (if_insn),
    .if_valid       (if_valid),
    .if_exp_misalign(if_exp_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive memory response, sample request, advance model
  task automatic cyc();
    if (mem_busy && mem_cnt == 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = data_of(mem_addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hDEAD_BEEF;
      if (mem_busy) mem_cnt--;
    end
    #1;
    req_s  = imem_req;
    addr_s = imem_addr;
    chk("single_outstanding", 32'(req_s & mem_busy & ~imem_rvalid), 32'd0);
    if (imem_rvalid) mem_busy = 1'b0;
    if (req_s) begin
      mem_busy = 1'b1;
      mem_cnt  = lat - 1;
      mem_addr = addr_s;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    branch_taken = 1'b0;
    pc_stall = 1'b0;
    if_stall = 1'b0;
    if_flush = 1'b0;
    repeat (5) cyc();
    chk("rst_req", 32'(req_s), 32'd0);
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_insn", if_insn, NOP);
    chk("rst_pc", if_pc, 32'd0);
    chk("rst_exp", 32'(if_exp_misalign), 32'd0);
    rst_n = 1'b1;
    cyc();
    chk("boot_no_req", 32'(req_s), 32'd0);
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; pc_stall = 1'b0; if_stall = 1'b0; if_flush = 1'b0;
    branch_taken = 1'b0; branch_target = 32'd0;
    imem_rvalid = 1'b0; imem_rdata = 32'd0;
    lat = 1; mem_busy = 1'b0; mem_cnt = 0; mem_addr = 32'd0;
    @(posedge clk); #1;

    // Zero-wait memory: one fetch per cycle, IF/ID two cycles behind
    do_reset();
    lat = 1;
    for (int i = 0; i < 7; i++) begin
      cyc();
      chk("s1_req", 32'(req_s), 32'd1);
      chk("s1_addr", addr_s, 32'(4 * i));
      if (i == 0) begin
        chk("s1_bubble", 32'(if_valid), 32'd0);
      end else begin
        chk("s1_valid", 32'(if_valid), 32'd1);
        chk("s1_pc", if_pc, 32'(4 * (i - 1)));
        chk("s1_insn", if_insn, data_of(32'(4 * (i - 1))));
      end
    end

    // Three wait states: one request every four cycles, bubbles between
    do_reset();
    lat = 4;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("s2_req", 32'(req_s), 32'd1);
      chk("s2_addr", addr_s, 32'(4 * k));
      if (k > 0) begin
        chk("s2_valid", 32'(if_valid), 32'd1);
        chk("s2_pc", if_pc, 32'(4 * (k - 1)));
        chk("s2_insn", if_insn, data_of(32'(4 * (k - 1))));
      end
      for (int j = 0; j < 3; j++) begin
        cyc();
        chk("s2_no_req", 32'(req_s), 32'd0);
        chk("s2_bub_valid", 32'(if_valid), 32'd0);
        chk("s2_bub_insn", if_insn, NOP);
      end
    end

    // Stall while a response returns: skid captures it, no drop or duplicate
    do_reset();
    lat = 2;
    cyc(); chk("s3_addr0", addr_s, 32'd0);
    cyc(); chk("s3_wait", 32'(req_s), 32'd0);
    cyc(); chk("s3_addr4", addr_s, 32'd4); chk("s3_req4", 32'(req_s), 32'd1);
    chk("s3_pc0", if_pc, 32'd0);
    pc_stall = 1'b1; if_stall = 1'b1;
    for (int j = 0; j < 3; j++) begin
      cyc();
      chk("s3_stall_req", 32'(req_s), 32'd0);
      chk("s3_hold_pc", if_pc, 32'd0);
      chk("s3_hold_valid", 32'(if_valid), 32'd1);
      chk("s3_hold_insn", if_insn, data_of(32'd0));
    end
    pc_stall = 1'b0; if_stall = 1'b0;
    cyc();
    chk("s3_skid_req", 32'(req_s), 32'd0);
    chk("s3_skid_pc", if_pc, 32'd4);
    chk("s3_skid_valid", 32'(if_valid), 32'd1);
    chk("s3_skid_insn", if_insn, data_of(32'd4));
    cyc();
    chk("s3_resume_req", 32'(req_s), 32'd1);
    chk("s3_resume_addr", addr_s, 32'd8);
    chk("s3_resume_bubble", 32'(if_valid), 32'd0);
    cyc(); chk("s3_wait2", 32'(req_s), 32'd0);
    cyc();
    chk("s3_addr12", addr_s, 32'd12);
    chk("s3_pc8", if_pc, 32'd8);
    chk("s3_insn8", if_insn, data_of(32'd8));

    // Redirect with a response in flight, then a deferred misaligned redirect
    do_reset();
    lat = 2;
    cyc(); chk("s4_addr0", addr_s, 32'd0);
    branch_taken = 1'b1; branch_target = 32'h100;
    cyc(); chk("s4_br_req", 32'(req_s), 32'd0); chk("s4_br_kill", 32'(if_valid), 32'd0);
    branch_taken = 1'b0;
    cyc(); chk("s4_discard_req", 32'(req_s), 32'd0); chk("s4_discard_valid", 32'(if_valid), 32'd0);
    cyc(); chk("s4_tgt_req", 32'(req_s), 32'd1); chk("s4_tgt_addr", addr_s, 32'h100);
    cyc(); chk("s4_wait", 32'(req_s), 32'd0);
    cyc();
    chk("s4_next_addr", addr_s, 32'h104);
    chk("s4_pc", if_pc, 32'h100);
    chk("s4_valid", 32'(if_valid), 32'd1);
    chk("s4_insn", if_insn, data_of(32'h100));
    branch_taken = 1'b1; branch_target = 32'h102;
    cyc(); chk("s4_mis_req", 32'(req_s), 32'd0); chk("s4_mis_pending", 32'(if_valid), 32'd0);
    branch_taken = 1'b0;
    cyc();
    chk("s4_mis_req2", 32'(req_s), 32'd0);
    chk("s4_mis_valid", 32'(if_valid), 32'd1);
    chk("s4_mis_exp", 32'(if_exp_misalign), 32'd1);
    chk("s4_mis_pc", if_pc, 32'h102);
    chk("s4_mis_insn", if_insn, NOP);
    cyc(); chk("s4_exp_req", 32'(req_s), 32'd0);
    branch_taken = 1'b1; branch_target = 32'h200;
    cyc(); chk("s4_leave_req", 32'(req_s), 32'd0); chk("s4_leave_exp", 32'(if_exp_misalign), 32'd0);
    branch_taken = 1'b0;
    cyc(); chk("s4_200_req", 32'(req_s), 32'd1); chk("s4_200_addr", addr_s, 32'h200);

    // Misaligned redirect with nothing outstanding
    do_reset();
    lat = 1;
    branch_taken = 1'b1; branch_target = 32'h102;
    cyc();
    chk("s5_req", 32'(req_s), 32'd0);
    chk("s5_valid", 32'(if_valid), 32'd1);
    chk("s5_exp", 32'(if_exp_misalign), 32'd1);
    chk("s5_pc", if_pc, 32'h102);
    chk("s5_insn", if_insn, NOP);
    branch_taken = 1'b0;
    for (int j = 0; j < 3; j++) begin
      cyc(); chk("s5_halt_req", 32'(req_s), 32'd0);
    end
    branch_taken = 1'b1; branch_target = 32'h200;
    cyc(); chk("s5_br_req", 32'(req_s), 32'd0);
    branch_taken = 1'b0;
    cyc(); chk("s5_200_req", 32'(req_s), 32'd1); chk("s5_200_addr", addr_s, 32'h200);

    // Fetch PC wraps from the top of the address space
    do_reset();
    lat = 1;
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
    cyc(); chk("s6_br_req", 32'(req_s), 32'd0);
    branch_taken = 1'b0;
    cyc(); chk("s6_top_addr", addr_s, 32'hFFFF_FFFC); chk("s6_top_req", 32'(req_s), 32'd1);
    cyc();
    chk("s6_wrap_addr", addr_s, 32'h0000_0000);
    chk("s6_wrap_req", 32'(req_s), 32'd1);
    chk("s6_wrap_pc", if_pc, 32'hFFFF_FFFC);
    chk("s6_wrap_insn", if_insn, data_of(32'hFFFF_FFFC));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the 5-stage RV32I pipeline. It sits directly upstream of the ID stage and downstream of the pipeline controller: it owns the fetch PC, drives the instruction-memory request interface with one outstanding request, and loads the IF/ID pipeline register. It obeys the controller's `pc_stall`, `if_stall` and `if_flush` outputs and the EX-stage redirect.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `NOP_INSN`, 32'h0000_0013, bubble instruction (`addi x0,x0,0`)

- `clk` in 1: rising-edge clock
- `rst_n` in 1: reset, asynchronous, active-low
- `pc_stall` in 1: freeze fetch PC and block new requests
- `if_stall` in 1: hold IF/ID register and block new requests
- `if_flush` in 1: kill IF/ID contents (control hazard)
- `branch_taken` in 1: redirect fetch this cycle
- `branch_target` in 32: redirect address
- `imem_req` out 1: request valid; memory accepts unconditionally
- `imem_addr` out 32: request address
- `imem_rvalid` in 1: response valid; in order, exactly one per request, ≥1 cycle after the request
- `imem_rdata` in 32: response instruction
- `if_pc` out 32: IF/ID PC
- `if_insn` out 32: IF/ID instruction
- `if_valid` out 1: IF/ID holds a real instruction
- `if_exp_misalign` out 1: IF/ID entry is a misaligned-fetch exception

## Operation
- Registers:
  - `fetch_pc`, `req_pc`: PC of the outstanding request.
  - One-entry skid buffer: `skid_valid`, `skid_pc`, `skid_insn`.
  - IF/ID register.
  - FSM.
- FSM states: BOOT (reset state), IDLE (nothing outstanding), WAIT (request outstanding), WAIT_DISCARD (outstanding response to be dropped), EXP (halted after misaligned redirect).
- `issue` = state∈{IDLE} or (state==WAIT & `imem_rvalid`), and !`pc_stall` & !`if_stall` & !`skid_valid` & !`branch_taken` & !`if_flush`.
- `imem_req`=`issue`; `imem_addr`=`fetch_pc`. Both are combinational. `imem_req` is 0 in BOOT, WAIT_DISCARD and EXP.
- On `issue`:
  - `req_pc`<=`fetch_pc`.
  - `fetch_pc`<=`fetch_pc`+4, modulo 2^32 (wraps 32'hFFFF_FFFC→0).
  - Next state WAIT.
- WAIT & `imem_rvalid` & !`issue` → IDLE.
- Redirect (`branch_taken`) has priority over all stalls:
  - `fetch_pc`<=`branch_target`; skid cleared.
  - If WAIT and no `imem_rvalid` this cycle → WAIT_DISCARD. Otherwise → IDLE.
  - If `branch_target[1:0]`≠0 → EXP: IF/ID loads `if_valid`=1, `if_exp_misalign`=1, `if_pc`=target, `if_insn`=NOP. This load is deferred past WAIT_DISCARD if needed. EXP is left only by the next redirect.
- WAIT_DISCARD & `imem_rvalid`: response dropped; → IDLE (or EXP if pending misalign).
- `pc_stall` without `if_stall`: no issue; a returning response still loads IF/ID or skid.
- Accepted response: `imem_rvalid` in WAIT.
  - If `if_stall` or `skid_valid`, it goes to skid.
  - Otherwise it goes to IF/ID.
- IF/ID update priority, per cycle:
  1. `if_flush` | `branch_taken` → `if_valid`=0, `if_insn`=NOP, `if_exp_misalign`=0, `if_pc` held. The misalign case above is the one exception.
  2. `if_stall` → hold.
  3. `skid_valid` → load skid; skid empties.
  4. Accepted response → load (`req_pc`, `imem_rdata`, valid=1).
  5. Otherwise → bubble (valid=0, NOP).
- Skid never overflows: issue is blocked while skid is full or `if_stall`=1, so at most one response can arrive.

## Timing
- Reset (async): state BOOT, `fetch_pc`=`RESET_PC`, skid empty, `if_valid`=0, `if_insn`=NOP, `if_pc`=0, `if_exp_misalign`=0, `imem_req`=0.
- BOOT → IDLE on the first clock after release. The first `imem_req` is asserted the cycle after that.
- Zero-wait memory (`imem_rvalid` at cycle n+1 for a request at cycle n): one instruction per cycle. The instruction requested at n is visible on IF/ID at n+2.
- Redirect at cycle n: the target request is issued at n+1 if nothing is outstanding and no stall is active.
- Reset asserted mid-request: the state is dropped; a late `imem_rvalid` arriving in BOOT/IDLE is ignored.

## Test plan
- Reset release, zero-wait memory returning `imem_rdata`=addr^32'hA5A5_0000: `imem_addr` 0,4,8,… on consecutive cycles; `if_pc`/`if_insn` follow 2 cycles later with `if_valid`=1.
- 3-wait-state memory: one request per 4 cycles; bubbles (valid=0, NOP) in between; never two requests outstanding.
- `if_stall`=`pc_stall`=1 for 3 cycles while a response returns: response lands in skid; IF/ID holds; on release, the skid entry appears next, then fetch resumes at the correct PC with no drop or duplicate.
- `branch_taken` with target 0x100 while a 2-cycle response is outstanding: old response discarded; next request addr 0x100; IF/ID shows `if_pc`=0x100.
- `branch_taken` with target 0x102: no memory request; IF/ID `if_exp_misalign`=1, `if_pc`=0x102; `imem_req` stays 0 until a redirect to 0x200.
- `fetch_pc` starting at 0xFFFF_FFFC: next request address 0x0000_0000.
